bit_deserializer: RTL and testbench

//   Receive end of the single-bit serial link: collects WIDTH data bits (plus optional parity)

---
 rtl/bit_deserializer_pkg.sv | 19 +
 rtl/deser_shift_capture.sv | 74 +++++++
 rtl/bit_deserializer.sv | 122 ++++++++++++
 tb/tb_bit_deserializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared definitions for the serial link receive path (and the word serializer).
//   state_e      : receive FSM states
//   MAX_FRAME    : widest frame (32 data bits + parity) the helpers accept
//   parity_even  : bit that makes the vector's ones-count even; a received
//                  frame with correct even parity therefore reduces to 0
package bit_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned MAX_FRAME = 33;

  function automatic logic parity_even(input logic [MAX_FRAME-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/deser_shift_capture.sv
// Shift register and bit counter for one serial frame.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_start      : bit strobe with start-of-frame; i_bit becomes frame bit 0
//   i_shift      : bit strobe inside a frame; i_bit appended
//   i_bit        : serial data bit
//   o_word       : data bits of the frame including this cycle's bit (MSB_FIRST-aware)
//   o_par_bit    : parity bit of the frame including this cycle's bit (0 when PARITY_EN=0)
//   o_done       : this cycle's strobe completes the frame (combinational pulse)
module deser_shift_capture #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_start,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word,
  output logic             o_par_bit,
  output logic             o_done
);

  localparam int unsigned N  = WIDTH + PARITY_EN;
  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]     r_sr;
  logic [N-1:0]     w_sr_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_frame;

  // Bits enter at the LSB, so after N bits the first received bit sits at
  // r_sr[N-1] and any parity bit at r_sr[0].
  always_comb begin
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    o_done     = 1'b0;
    if (i_start) begin
      w_sr_next  = {{(N-1){1'b0}}, i_bit};
      w_cnt_next = CW'(1);
    end else if (i_shift) begin
      w_sr_next = {r_sr[N-2:0], i_bit};
      if (r_cnt == CW'(N - 1)) begin
        o_done     = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // The word is taken from the next-state value so the top can register it
  // on the same edge as the final strobe.
  always_comb begin
    w_frame   = w_sr_next[N-1 -: WIDTH];
    o_word    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_word[i] = (MSB_FIRST != 0) ? w_frame[i] : w_frame[WIDTH-1-i];
    end
    o_par_bit = (PARITY_EN != 0) ? w_sr_next[0] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_next;
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// Receive end of the single-bit serial link: assembles WIDTH data bits (plus an
// optional even-parity bit) into a word held in a one-entry valid/ready buffer.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   enable_i           : 0 freezes frame progress and ignores bit inputs
//   sof_i, bit_i,
//   bit_valid_i        : serial stream; a bit is taken when enable_i && bit_valid_i
//   data_o, valid_o,
//   ready_i            : word output, consumed when valid_o && ready_i
//   parity_err_o       : sticky, word delivered with bad parity
//   overrun_o          : sticky, completed word dropped because the buffer was full
//   clear_i            : clears both sticky flags (a same-cycle set wins)
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             sof_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             overrun_o,
  input  logic             clear_i
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_strobe;
  logic             w_start;
  logic             w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_par_bit;
  logic             w_done;
  logic             w_load;
  logic             w_drop;
  logic             w_par_bad;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_ovr;

  // sof_i restarts a frame from any state; plain strobes only count in SHIFT.
  assign w_strobe = enable_i & bit_valid_i;
  assign w_start  = w_strobe & sof_i;
  assign w_shift  = w_strobe & ~sof_i & (r_state == SHIFT);

  deser_shift_capture #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .PARITY_EN(PARITY_EN)
  ) u_capture (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_bit    (bit_i),
    .o_word   (w_word),
    .o_par_bit(w_par_bit),
    .o_done   (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = SHIFT;
    end else if (w_done) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A completion may load in the same cycle the held word is accepted.
  assign w_load    = w_done & (~r_valid | ready_i);
  assign w_drop    = w_done & r_valid & ~ready_i;
  assign w_par_bad = (PARITY_EN != 0) && parity_even(MAX_FRAME'({w_word, w_par_bit}));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_load && w_par_bad) begin
        r_perr <= 1'b1;
      end else if (clear_i) begin
        r_perr <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clear_i) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_perr;
  assign overrun_o    = r_ovr;

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer. Three instances share one input
// stream: [0] MSB first, [1] LSB first, [2] MSB first with even parity.
// Each is compared every cycle against a frame-level reference model, with
// extra fixed-value checks on the directed frames.
module tb_bit_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic t_rst, t_en, t_sof, t_bit, t_bv, t_rdy, t_clr;

  logic [7:0] d_data  [3];
  logic       d_valid [3];
  logic       d_perr  [3];
  logic       d_ovr   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bit_deserializer #(
      .WIDTH    (8),
      .MSB_FIRST((g == 1) ? 0 : 1),
      .PARITY_EN((g == 2) ? 1 : 0)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (t_rst),
      .enable_i    (t_en),
      .sof_i       (t_sof),
      .bit_i       (t_bit),
      .bit_valid_i (t_bv),
      .data_o      (d_data[g]),
      .valid_o     (d_valid[g]),
      .ready_i     (t_rdy),
      .parity_err_o(d_perr[g]),
      .overrun_o   (d_ovr[g]),
      .clear_i     (t_clr)
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bits collected into a queue since the last start-of-frame;
  // a frame is complete when the queue holds the frame length.
  bit       m_q     [3][$];
  bit [7:0] m_data  [3];
  bit       m_valid [3];
  bit       m_perr  [3];
  bit       m_ovr   [3];

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int  flen;
      bit  done;
      bit  par_bad;
      bit [7:0] w;
      int  ones;
      flen    = (k == 2) ? 9 : 8;
      done    = 0;
      par_bad = 0;
      w       = '0;
      if (t_rst) begin
        m_q[k].delete();
        m_data[k]  = '0;
        m_valid[k] = 0;
        m_perr[k]  = 0;
        m_ovr[k]   = 0;
        continue;
      end
      if (t_en && t_bv) begin
        if (t_sof) begin
          m_q[k].delete();
          m_q[k].push_back(t_bit);
        end else if (m_q[k].size() != 0) begin
          m_q[k].push_back(t_bit);
        end
        if (m_q[k].size() == flen) begin
          done = 1;
          ones = 0;
          for (int i = 0; i < flen; i++) ones += int'(m_q[k][i]);
          for (int i = 0; i < 8; i++) begin
            if (k == 1) w[i] = m_q[k][i];
            else        w[7-i] = m_q[k][i];
          end
          par_bad = (k == 2) && (ones % 2 == 1);
          m_q[k].delete();
        end
      end
      if (t_clr) begin
        m_perr[k] = 0;
        m_ovr[k]  = 0;
      end
      if (done && (!m_valid[k] || t_rdy)) begin
        m_data[k]  = w;
        m_valid[k] = 1;
        if (par_bad) m_perr[k] = 1;
      end else if (done) begin
        m_ovr[k] = 1;
      end else if (m_valid[k] && t_rdy) begin
        m_valid[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_data", k),  32'(d_data[k]),  32'(m_data[k]));
      chk($sformatf("u%0d_valid", k), 32'(d_valid[k]), 32'(m_valid[k]));
      chk($sformatf("u%0d_perr", k),  32'(d_perr[k]),  32'(m_perr[k]));
      chk($sformatf("u%0d_ovr", k),   32'(d_ovr[k]),   32'(m_ovr[k]));
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, check 1 ns later.
  task automatic cyc(input logic en, input logic sof, input logic b, input logic bv,
                     input logic rdy, input logic clr, input logic rst);
    t_en = en; t_sof = sof; t_bit = b; t_bv = bv; t_rdy = rdy; t_clr = clr; t_rst = rst;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  // Eight data strobes, first bit sent is w[7]; ready_i on the last strobe is rdy_last.
  task automatic send8(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i == 0, w[7-i], 1'b1, (i == 7) ? rdy_last : rdy, 1'b0, 1'b0);
    end
  endtask

  task automatic send_par(input logic p, input logic rdy);
    cyc(1'b1, 1'b0, p, 1'b1, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    t_rst = 1'b1; t_en = 1'b0; t_sof = 1'b0; t_bit = 1'b0; t_bv = 1'b0; t_rdy = 1'b0; t_clr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", 32'(d_valid[0]), 32'h0);
    chk("reset_data",  32'(d_data[0]),  32'h0);
    idle(2, 1'b1);

    // 1,0,1,0,0,1,0,1 then parity 0
    send8(8'hA5, 1'b1, 1'b1);
    chk("a5_msb_data",  32'(d_data[0]),  32'hA5);
    chk("a5_msb_valid", 32'(d_valid[0]), 32'h1);
    chk("a5_lsb_data",  32'(d_data[1]),  32'hA5);
    send_par(1'b0, 1'b1);
    chk("a5_msb_valid_drop", 32'(d_valid[0]), 32'h0);
    chk("a5_par_data",  32'(d_data[2]),  32'hA5);
    chk("a5_par_perr",  32'(d_perr[2]),  32'h0);
    idle(2, 1'b1);

    // 1,1,0,0,0,0,0,0 -> 8'h03 when LSB first
    send8(8'hC0, 1'b1, 1'b1);
    chk("lsb_03", 32'(d_data[1]), 32'h03);
    send_par(1'b0, 1'b1);
    idle(1, 1'b1);

    // bad parity still delivers the word
    send8(8'hA5, 1'b1, 1'b1);
    send_par(1'b1, 1'b1);
    chk("badpar_data", 32'(d_data[2]), 32'hA5);
    chk("badpar_perr", 32'(d_perr[2]), 32'h1);
    idle(3, 1'b1);
    chk("perr_sticky", 32'(d_perr[2]), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("perr_clear", 32'(d_perr[2]), 32'h0);

    // overrun with ready held low, then accept + completion together
    send8(8'h11, 1'b0, 1'b0);
    send_par(1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0);
    chk("ovr_data_hold", 32'(d_data[0]), 32'h11);
    chk("ovr_flag",      32'(d_ovr[0]),  32'h1);
    send_par(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_clear", 32'(d_ovr[0]), 32'h0);
    send8(8'h33, 1'b0, 1'b1);
    chk("swap_data",  32'(d_data[0]),  32'h33);
    chk("swap_valid", 32'(d_valid[0]), 32'h1);
    chk("swap_novr",  32'(d_ovr[0]),   32'h0);
    send_par(1'b0, 1'b0);
    idle(2, 1'b1);

    // restart after 5 bits
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'(i & 1), 1'b1, 1'b1, 1'b0, 1'b0);
    send8(8'h3C, 1'b1, 1'b1);
    chk("restart_3c", 32'(d_data[0]), 32'h3C);
    send_par(1'b0, 1'b1);
    idle(1, 1'b1);

    // enable low mid-frame
    begin
      logic [7:0] w;
      w = 8'h5A;
      for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, w[7-i], 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i == 1), 1'(i != 0), 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 3; i < 8; i++) cyc(1'b1, 1'b0, w[7-i], 1'b1, 1'b1, 1'b0, 1'b0);
      chk("enable_5a", 32'(d_data[0]), 32'h5A);
    end
    send_par(1'b0, 1'b1);
    idle(1, 1'b1);

    // reset mid-frame and with a word buffered
    for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_valid", 32'(d_valid[0]), 32'h0);
    send8(8'hFF, 1'b0, 1'b0);
    chk("rst_pre_valid", 32'(d_valid[0]), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_buf_valid", 32'(d_valid[0]), 32'h0);
    chk("rst_buf_data",  32'(d_data[0]),  32'h0);
    send8(8'hFF, 1'b1, 1'b1);
    chk("fresh_ff", 32'(d_data[0]), 32'hFF);
    send_par(1'b0, 1'b1);
    chk("fresh_ff_par", 32'(d_data[2]), 32'hFF);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(7, 0) != 0,
          $urandom_range(9, 0) == 0,
          1'($urandom),
          $urandom_range(3, 0) != 0,
          1'($urandom),
          $urandom_range(39, 0) == 0,
          $urandom_range(499, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
